// File: rtl/tx_burst_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tx_burst_sequencer
// Description : Frames the TX payload counter into bursts of programmable
//               length with programmable idle gaps. Supports one-shot error
//               injection and keeps completed/aborted burst statistics.
// Revision    : 1.0 - initial release
// ============================================================================
module tx_burst_sequencer #(
  parameter int LEN_W = 16,
  parameter int GAP_W = 8
) (
  input  logic             clk_i,
  input  logic             reset_n_i,
  input  logic             run_i,
  input  logic             tx_ready_i,
  input  logic [LEN_W-1:0] burst_len_i,
  input  logic [GAP_W-1:0] gap_len_i,
  input  logic             err_inject_i,
  output logic             cnt_start_o,
  output logic             payload_error_o,
  output logic             data_valid_o,
  output logic             sof_o,
  output logic             eof_o,
  output logic             abort_o,
  output logic             busy_o,
  output logic [31:0]      burst_count_o,
  output logic [15:0]      abort_count_o
);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_WAIT_RDY = 2'd1,
    S_BURST    = 2'd2,
    S_GAP      = 2'd3
  } state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic [LEN_W-1:0] r_len;
  logic [LEN_W-1:0] r_idx;
  logic [LEN_W-1:0] w_len_eff;
  logic [GAP_W-1:0] r_gap_cnt;
  logic [GAP_W-1:0] w_gap_eff;
  logic             r_arm;
  logic             r_err;
  logic             w_enter_burst;
  logic             w_emit;
  logic             w_last;
  logic             w_abort;
  logic             w_start_run;

  // A zero length or gap behaves as one.
  assign w_len_eff   = (burst_len_i == '0) ? LEN_W'(1) : burst_len_i;
  assign w_gap_eff   = (gap_len_i == '0) ? GAP_W'(1) : gap_len_i;
  assign w_start_run = (r_state == S_IDLE) && run_i;

  // Next-state decode. Each BURST cycle decides whether the next word goes out
  // (ready high) or the burst is aborted (ready low); the word flops below
  // follow that decision, so abort naturally wins over eof.
  always_comb begin
    w_state_next  = r_state;
    w_enter_burst = 1'b0;
    w_emit        = 1'b0;
    w_last        = 1'b0;
    w_abort       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (run_i) w_state_next = S_WAIT_RDY;
      end
      S_WAIT_RDY: begin
        if (!run_i) begin
          w_state_next = S_IDLE;
        end else if (tx_ready_i) begin
          w_state_next  = S_BURST;
          w_enter_burst = 1'b1;
        end
      end
      S_BURST: begin
        if (!tx_ready_i) begin
          w_abort      = 1'b1;
          w_state_next = run_i ? S_WAIT_RDY : S_IDLE;
        end else begin
          w_emit = 1'b1;
          if (r_idx == r_len - LEN_W'(1)) begin
            w_last       = 1'b1;
            w_state_next = S_GAP;
          end
        end
      end
      S_GAP: begin
        if (r_gap_cnt <= GAP_W'(1)) begin
          if (!run_i) begin
            w_state_next = S_IDLE;
          end else if (tx_ready_i) begin
            w_state_next  = S_BURST;
            w_enter_burst = 1'b1;
          end else begin
            w_state_next = S_WAIT_RDY;
          end
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) r_state <= S_IDLE;
    else            r_state <= w_state_next;
  end

  // Burst/gap bookkeeping and error-injection arming.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_len     <= '0;
      r_idx     <= '0;
      r_gap_cnt <= '0;
      r_arm     <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      if (w_enter_burst) begin
        r_len <= w_len_eff;
        r_idx <= '0;
        r_err <= r_arm | err_inject_i;
        r_arm <= 1'b0;
      end else begin
        if (err_inject_i) r_arm <= 1'b1;
        if (w_emit)       r_idx <= r_idx + LEN_W'(1);
      end
      if (w_last)                  r_gap_cnt <= w_gap_eff;
      else if (r_state == S_GAP)   r_gap_cnt <= r_gap_cnt - GAP_W'(1);
    end
  end

  // Registered word framing and status outputs.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      cnt_start_o     <= 1'b0;
      data_valid_o    <= 1'b0;
      payload_error_o <= 1'b0;
      sof_o           <= 1'b0;
      eof_o           <= 1'b0;
      abort_o         <= 1'b0;
      busy_o          <= 1'b0;
    end else begin
      cnt_start_o     <= w_emit;
      data_valid_o    <= w_emit;
      payload_error_o <= w_emit & r_err;
      sof_o           <= w_emit && (r_idx == '0);
      eof_o           <= w_last;
      abort_o         <= w_abort;
      busy_o          <= (w_state_next != S_IDLE);
    end
  end

  // Statistics: cleared when a run starts, burst count wraps, abort count saturates.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      burst_count_o <= '0;
      abort_count_o <= '0;
    end else if (w_start_run) begin
      burst_count_o <= '0;
      abort_count_o <= '0;
    end else begin
      if (w_last) burst_count_o <= burst_count_o + 32'd1;
      if (w_abort && (abort_count_o != 16'hFFFF)) abort_count_o <= abort_count_o + 16'd1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_tx_burst_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_tx_burst_sequencer
// Description : Directed bench for tx_burst_sequencer with a word scoreboard
//               and a model of the downstream payload counter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tx_burst_sequencer;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        run = 1'b0;
  logic        ready = 1'b0;
  logic [15:0] burst_len = 16'd0;
  logic [7:0]  gap_len = 8'd0;
  logic        err_inject = 1'b0;
  logic        cnt_start_o, payload_error_o, data_valid_o, sof_o, eof_o, abort_o, busy_o;
  logic [31:0] burst_count_o;
  logic [15:0] abort_count_o;

  typedef struct packed {
    logic        sof;
    logic        eof;
    logic        err;
    logic [31:0] data;
  } exp_t;

  exp_t        q[$];
  int          n_total = 0;
  int          n_pass = 0;
  int          n_fail = 0;
  int          n_abort_seen = 0;
  logic [31:0] cnt;
  logic [31:0] data_out;

  tx_burst_sequencer #(.LEN_W(16), .GAP_W(8)) dut (
    .clk_i          (clk),
    .reset_n_i      (reset_n),
    .run_i          (run),
    .tx_ready_i     (ready),
    .burst_len_i    (burst_len),
    .gap_len_i      (gap_len),
    .err_inject_i   (err_inject),
    .cnt_start_o    (cnt_start_o),
    .payload_error_o(payload_error_o),
    .data_valid_o   (data_valid_o),
    .sof_o          (sof_o),
    .eof_o          (eof_o),
    .abort_o        (abort_o),
    .busy_o         (busy_o),
    .burst_count_o  (burst_count_o),
    .abort_count_o  (abort_count_o)
  );

  always #5 clk = ~clk;

  // Downstream payload counter: counts while start is high, clears otherwise.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) cnt <= 32'd0;
    else          cnt <= cnt_start_o ? cnt + 32'd1 : 32'd0;
  end
  assign data_out = payload_error_o ? ~cnt : cnt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_burst(input int len, input logic err, input int nwords);
    exp_t e;
    for (int i = 0; i < nwords; i++) begin
      e.sof  = (i == 0);
      e.eof  = (i == len - 1);
      e.err  = err;
      e.data = err ? ~32'(i) : 32'(i);
      q.push_back(e);
    end
  endtask

  task automatic wait_sof();
    int n = 0;
    do begin @(negedge clk); n++; end while (!sof_o && n < 60);
    chk("wait_sof", 32'(sof_o), 32'd1);
  endtask

  task automatic wait_eof();
    int n = 0;
    do begin @(negedge clk); n++; end while (!eof_o && n < 60);
    chk("wait_eof", 32'(eof_o), 32'd1);
  endtask

  task automatic wait_idle();
    int n = 0;
    do begin @(negedge clk); n++; end while (busy_o && n < 60);
    chk("wait_idle", 32'(busy_o), 32'd0);
  endtask

  // Scoreboard: every valid word is compared with the next expected entry.
  always @(negedge clk) begin
    if (reset_n) begin
      if (abort_o) n_abort_seen++;
      if (data_valid_o) begin
        if (q.size() == 0) begin
          chk("unexpected_word", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("word_sof", 32'(sof_o), 32'(e.sof));
          chk("word_eof", 32'(eof_o), 32'(e.eof));
          chk("word_err", 32'(payload_error_o), 32'(e.err));
          chk("word_data", data_out, e.data);
          chk("word_start", 32'(cnt_start_o), 32'd1);
        end
      end
    end
  end

  initial begin
    logic [6:0] pat7;
    logic [4:0] pat5;

    // Reset state.
    repeat (2) @(negedge clk);
    chk("rst_start", 32'(cnt_start_o), 32'd0);
    chk("rst_valid", 32'(data_valid_o), 32'd0);
    chk("rst_err", 32'(payload_error_o), 32'd0);
    chk("rst_sof", 32'(sof_o), 32'd0);
    chk("rst_eof", 32'(eof_o), 32'd0);
    chk("rst_abort", 32'(abort_o), 32'd0);
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_bcnt", burst_count_o, 32'd0);
    chk("rst_acnt", 32'(abort_count_o), 32'd0);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    // Basic framing len=4 gap=2; run drops early in the second burst.
    burst_len = 16'd4; gap_len = 8'd2; ready = 1'b1;
    push_burst(4, 1'b0, 4);
    push_burst(4, 1'b0, 4);
    run = 1'b1;
    wait_sof();
    pat7[6] = data_valid_o;
    for (int i = 5; i >= 0; i--) begin @(negedge clk); pat7[i] = data_valid_o; end
    chk("framing_pattern", 32'(pat7), 32'(7'b1111001));
    run = 1'b0;
    wait_idle();
    chk("framing_bcnt", burst_count_o, 32'd2);

    // len=0 gap=0: single-word bursts separated by one idle cycle; counts cleared on run.
    burst_len = 16'd0; gap_len = 8'd0;
    push_burst(1, 1'b0, 1);
    push_burst(1, 1'b0, 1);
    push_burst(1, 1'b0, 1);
    run = 1'b1;
    @(negedge clk);
    chk("run_clears_bcnt", burst_count_o, 32'd0);
    wait_sof();
    pat5[4] = data_valid_o;
    for (int i = 3; i >= 0; i--) begin @(negedge clk); pat5[i] = data_valid_o; end
    chk("len0_pattern", 32'(pat5), 32'(5'b10101));
    run = 1'b0;
    wait_idle();
    chk("len0_bcnt", burst_count_o, 32'd3);

    // Error injection: pulse in the gap, then pulse on the burst-entry cycle.
    burst_len = 16'd3; gap_len = 8'd4;
    push_burst(3, 1'b0, 3);
    push_burst(3, 1'b1, 3);
    push_burst(3, 1'b1, 3);
    push_burst(3, 1'b0, 3);
    run = 1'b1;
    wait_eof();
    err_inject = 1'b1;
    @(negedge clk);
    err_inject = 1'b0;
    wait_eof();
    repeat (3) @(negedge clk);
    err_inject = 1'b1;
    @(negedge clk);
    err_inject = 1'b0;
    wait_sof();
    wait_eof();
    wait_sof();
    run = 1'b0;
    wait_idle();
    chk("errinj_bcnt", burst_count_o, 32'd4);

    // Abort: ready drops so that word 2 of an 8-word burst is not sent.
    burst_len = 16'd8; gap_len = 8'd2; ready = 1'b1;
    push_burst(8, 1'b0, 2);
    run = 1'b1;
    wait_sof();
    @(negedge clk);
    ready = 1'b0;
    @(negedge clk);
    chk("abort_pulse", 32'(abort_o), 32'd1);
    chk("abort_no_eof", 32'(eof_o), 32'd0);
    chk("abort_no_valid", 32'(data_valid_o), 32'd0);
    chk("abort_acnt", 32'(abort_count_o), 32'd1);
    chk("abort_bcnt", burst_count_o, 32'd0);
    @(negedge clk);
    chk("abort_one_cycle", 32'(abort_o), 32'd0);
    chk("abort_busy", 32'(busy_o), 32'd1);
    push_burst(8, 1'b0, 8);
    ready = 1'b1;
    wait_sof();
    run = 1'b0;
    wait_idle();
    chk("abort_after_bcnt", burst_count_o, 32'd1);
    chk("abort_after_acnt", 32'(abort_count_o), 32'd1);
    chk("abort_seen", n_abort_seen, 32'd1);

    // Graceful stop: run drops on word 1, burst completes, idle after one gap cycle.
    burst_len = 16'd4; gap_len = 8'd1; ready = 1'b0;
    run = 1'b1;
    @(negedge clk);
    chk("restart_bcnt", burst_count_o, 32'd0);
    chk("restart_acnt", 32'(abort_count_o), 32'd0);
    push_burst(4, 1'b0, 4);
    ready = 1'b1;
    wait_sof();
    @(negedge clk);
    run = 1'b0;
    wait_eof();
    chk("stop_busy_eof", 32'(busy_o), 32'd1);
    @(negedge clk);
    chk("stop_busy_idle", 32'(busy_o), 32'd0);
    chk("stop_valid", 32'(data_valid_o), 32'd0);
    chk("stop_bcnt", burst_count_o, 32'd1);

    // Asynchronous reset in the middle of a burst.
    burst_len = 16'd8; gap_len = 8'd2; ready = 1'b1;
    push_burst(8, 1'b0, 3);
    run = 1'b1;
    wait_sof();
    repeat (2) @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    chk("arst_start", 32'(cnt_start_o), 32'd0);
    chk("arst_valid", 32'(data_valid_o), 32'd0);
    chk("arst_sof", 32'(sof_o), 32'd0);
    chk("arst_eof", 32'(eof_o), 32'd0);
    chk("arst_abort", 32'(abort_o), 32'd0);
    chk("arst_busy", 32'(busy_o), 32'd0);
    chk("arst_bcnt", burst_count_o, 32'd0);
    run = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("post_rst_busy", 32'(busy_o), 32'd0);
    chk("post_rst_valid", 32'(data_valid_o), 32'd0);
    ready = 1'b0;
    run = 1'b1;
    @(negedge clk);
    chk("post_rst_run_busy", 32'(busy_o), 32'd1);
    run = 1'b0;
    repeat (2) @(negedge clk);
    chk("sb_empty", q.size(), 32'd0);
    chk("abort_seen_final", n_abort_seen, 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/tx_burst_sequencer.md
# tx_burst_sequencer

Sequencer that drives the TX payload counter's `start_i` and `payload_error_i` inputs. It turns the UART-controlled run request into framed bursts of counter data toward the LiteFast transmitter, with programmable burst length, inter-burst gap and one-shot error injection. It also reports completed and aborted burst counts back to the UART interface.

## Interface
Parameters:
- LEN_W, 16: width of burst length input.
- GAP_W, 8: width of gap length input.

Ports:
- clk_i  in  1  transceiver TX clock
- reset_n_i  in  1  asynchronous, active-low reset
- run_i  in  1  level; 1 = generate bursts (from UART_IF)
- tx_ready_i  in  1  transmitter/link ready
- burst_len_i  in  LEN_W  words per burst; 0 treated as 1
- gap_len_i  in  GAP_W  idle cycles between bursts; 0 treated as 1
- err_inject_i  in  1  one-cycle pulse: corrupt next burst
- cnt_start_o  out  1  to counter `start_i`
- payload_error_o  out  1  to counter `payload_error_i`
- data_valid_o  out  1  payload word valid (equals cnt_start_o)
- sof_o  out  1  first word of burst
- eof_o  out  1  last word of burst
- abort_o  out  1  one-cycle pulse, burst aborted
- busy_o  out  1  state != IDLE
- burst_count_o  out  32  completed bursts, wraps
- abort_count_o  out  16  aborted bursts, saturates at 16'hFFFF

## Operation
- States: IDLE, WAIT_RDY, BURST, GAP.
- IDLE: run_i=1 -> WAIT_RDY. On this transition, clear burst_count_o and abort_count_o.
- WAIT_RDY: run_i=0 -> IDLE. Otherwise tx_ready_i=1 -> BURST.
- On entry to BURST:
  - Latch len = max(burst_len_i,1).
  - Set word index to 0.
  - Set payload_error_o = arm | err_inject_i, then clear arm.
- Outside BURST entry, err_inject_i=1 sets arm. Multiple pulses coalesce into one corrupted burst.
- BURST: cnt_start_o=1 and the word index increments every cycle.
  - sof_o=1 when index=0. eof_o=1 when index=len-1 (both high for len=1).
  - On the eof cycle, burst_count_o increments, then next state is GAP.
  - tx_ready_i=0 in any BURST cycle: abort. Next state is WAIT_RDY (or IDLE if run_i=0); abort_o pulses; abort_count_o increments (saturating); burst_count_o is unchanged; eof_o is not asserted. Abort has priority over eof in the same cycle.
  - run_i=0 during BURST does not truncate; the burst completes.
- GAP: lasts max(gap_len_i,1) cycles, with gap_len_i sampled on GAP entry. cnt_start_o=0 for the whole gap, so the counter clears to 0. At gap end:
  - run_i=0 -> IDLE
  - else tx_ready_i=1 -> BURST
  - else WAIT_RDY
- payload_error_o is held for the whole burst and cleared outside BURST.

## Timing
- All outputs are registered. Reset values: all 0, counts 0, state IDLE, arm 0.
- Reset asserted mid-burst clears all outputs asynchronously. No eof_o or abort_o is produced.
- First BURST cycle: cnt_start_o rises. The counter still holds 0, so data_out = index in every data_valid_o cycle; a burst carries 0..len-1 (or the inverse when payload_error_o=1).
- WAIT_RDY -> BURST takes 1 cycle after tx_ready_i is sampled high.
- Minimum cnt_start_o low time between bursts is 1 cycle, which guarantees the counter restart.
- burst_count_o wraps from 32'hFFFFFFFF to 0.
- burst_len_i and gap_len_i changes mid-burst or mid-gap do not affect the current burst or gap.

## Test plan
- Basic framing: run=1, ready=1, len=4, gap=2 -> valid pattern 1111 00 1111; data 0,1,2,3 each burst; sof on word 0, eof on word 3; burst_count_o=1,2,...
- len=0, gap=0 -> 1-word bursts alternating with 1 idle cycle; sof=eof=1 on each word; data always 0.
- Error injection: err_inject pulse during GAP, len=3 -> next burst data FFFFFFFF, FFFFFFFE, FFFFFFFD with payload_error_o=1; the following burst is normal. A pulse on the BURST-entry cycle corrupts that burst.
- Abort: ready drops on word 2 of len=8 -> abort_o pulses once, abort_count_o=1, burst_count_o unchanged, no eof; when ready returns, the new burst restarts at data 0.
- Graceful stop: run drops on word 1 of len=4 -> words 2,3 still sent, eof asserted, then IDLE after 1 GAP cycle with busy_o=0. A later run rise clears both counts.
- Async reset asserted mid-burst -> all outputs 0 immediately; after release, state is IDLE and remains there until run_i=1.
